// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared pipeline constants and skid-register state encoding
package pipe_skid_reg_pkg;

    localparam int IFID_DATA_W = 64;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready pipeline register; out_data and in_ready come straight from flops
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = IFID_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    skid_state_e       state;
    logic [DATA_W-1:0] skid;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= RESET_VAL;
            skid      <= RESET_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else if (flush) begin
            state     <= EMPTY;
            out_data  <= RESET_VAL;
            skid      <= RESET_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= HALF;
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                HALF: begin
                    // out_valid is always set here, so out_ready alone decides out_fire
                    if (in_fire && out_ready) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        state     <= FULL;
                        skid      <= in_data;
                        in_ready  <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_data  <= RESET_VAL;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state     <= HALF;
                        out_data  <= skid;
                        skid      <= RESET_VAL;
                        in_ready  <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_data  <= RESET_VAL;
                    skid      <= RESET_VAL;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random checks of pipe_skid_reg against a queue-based model
module tb_pipe_skid_reg;

    localparam int DW = 64;
    localparam logic [DW-1:0] RV = 64'hDEAD_0000_0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    occupancy;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".occ"}, DW'(occupancy), DW'(q.size()));
        check({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
        check({tag, ".in_ready"}, DW'(in_ready), DW'(q.size() < 2));
        check({tag, ".out_data"}, out_data, q.size() > 0 ? q[0] : RV);
    endtask

    // one clock: drive inputs, let the edge happen, advance the model, compare
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic r, input logic f);
        logic in_f;
        logic out_f;
        in_valid = v;
        in_data = d;
        out_ready = r;
        flush = f;
        in_f = v && (q.size() < 2);
        out_f = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(d);
        end
        compare(tag);
    endtask

    initial begin
        #12;
        compare("reset");
        #3 rst_n = 1'b1;
        #2;
        for (int i = 1; i <= 8; i++) step("stream", 1'b1, DW'(i), 1'b1, 1'b0);
        step("stream_drain", 1'b0, '0, 1'b1, 1'b0);
        step("stream_idle", 1'b0, '0, 1'b1, 1'b0);
        step("skid_a", 1'b1, 64'hA, 1'b1, 1'b0);
        step("skid_b", 1'b1, 64'hB, 1'b0, 1'b0);
        step("skid_c_held", 1'b1, 64'hC, 1'b0, 1'b0);
        check("skid_full_occ", DW'(occupancy), 64'd2);
        check("skid_full_head", out_data, 64'hA);
        step("skid_rel1", 1'b1, 64'hC, 1'b1, 1'b0);
        step("skid_rel2", 1'b1, 64'hC, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("skid_drain", 1'b0, '0, 1'b1, 1'b0);
        step("fl_a", 1'b1, 64'h11, 1'b0, 1'b0);
        step("fl_b", 1'b1, 64'h22, 1'b0, 1'b0);
        step("flush_full", 1'b1, 64'h33, 1'b0, 1'b1);
        check("flush_data", out_data, RV);
        step("post_flush", 1'b0, '0, 1'b1, 1'b0);
        step("half_a", 1'b1, 64'h44, 1'b0, 1'b0);
        step("half_swap", 1'b1, 64'h55, 1'b1, 1'b0);
        check("half_swap_data", out_data, 64'h55);
        step("full_b", 1'b1, 64'h66, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        compare("async_rst");
        #2 rst_n = 1'b1;
        step("after_rst", 1'b1, 64'h77, 1'b0, 1'b0);
        for (int i = 0; i < 10000; i++)
            step("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
